ps2_host_ctrl: RTL and testbench
================================

Name: ps2_host_ctrl

Overview:
Host-side PS/2 port controller that sequences the bidirectional PS2_CLK/PS2_DAT pair.
- Receives device-to-host frames and presents checked bytes.
- Runs the host-to-device command protocol (inhibit, request-to-send, bit shifting, ACK check).
- Arbitrates the shared two-wire bus between the receive path and a command requester.
- Sits between the board-level open-drain PS/2 pins and keyboard/mouse logic such as the PS/2 demo.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low hold before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum CLOCK_50 cycles between PS/2 falling edges inside a frame (15 ms).
- FILTER_LEN, 8: consecutive identical synchronized samples needed to change the filtered PS/2 clock.

Ports:
- CLOCK_50 input 1: system clock.
- Reset input 1: asynchronous, active-high reset.
- ps2_clk_in input 1: PS2_CLK pin readback (asynchronous).
- ps2_dat_in input 1: PS2_DAT pin readback (asynchronous).
- ps2_clk_oe output 1: 1 pulls PS2_CLK low; 0 releases it (high-Z).
- ps2_dat_oe output 1: 1 pulls PS2_DAT low; 0 releases it.
- cmd_valid input 1: requester has a command byte.
- cmd_data input 8: command byte.
- cmd_ready output 1: command accepted this cycle when cmd_valid=1.
- rx_valid output 1: one-cycle strobe, good frame received.
- rx_data output 8: received byte, held until the next rx_valid.
- rx_err output 1: one-cycle strobe, bad or timed-out receive frame.
- tx_done output 1: one-cycle strobe, command sent and device ACKed.
- tx_err output 1: one-cycle strobe, missing ACK or timeout during a command.
- busy output 1: state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ps2_clk_oe=0; ps2_dat_oe=0; cmd_ready=0 on the reset cycle; all strobes=0; rx_data=0x00; bit counter=0; timeout counter=0; filter=1.
- Input conditioning: 2-flop synchronizer on each pin, then a FILTER_LEN run-length filter on the clock. A fall strobe fires for one cycle when the filtered clock goes 1->0. Pin-to-strobe latency is 2+FILTER_LEN cycles. Data is sampled from the synchronized data on the fall strobe.
- Combinational: cmd_ready = (state==IDLE) && !fall.
- Priority: a device frame wins any same-cycle contest with cmd_valid.

States:
- IDLE: both oe=0.
  - fall -> RX; the first sampled bit is the start bit.
  - Else cmd_valid && cmd_ready -> latch cmd_data, compute odd parity, go to TX_INHIBIT.
- RX: capture 11 bits in order: start, D0..D7 (LSB first), parity, stop.
  - On the 11th fall, return to IDLE next cycle.
  - Good frame: start=0, odd parity over D0..D7 plus parity bit, stop=1 -> rx_valid=1 and rx_data updated on that same cycle.
  - Bad frame: rx_err=1 and rx_data unchanged.
- TX_INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
  - In the last inhibit cycle, assert ps2_dat_oe=1 (start bit).
  - Then go to TX_BITS with ps2_clk_oe=0 and ps2_dat_oe held at 1.
- TX_BITS: on falls 1..8, drive D0..D7; on fall 9, drive parity; on fall 10, release data (stop bit).
  - Driving a 0 means ps2_dat_oe=1; driving a 1 means ps2_dat_oe=0.
  - Fall 10 -> TX_ACK.
- TX_ACK: on fall 11, sample data.
  - Data=0 -> wait until both synchronized lines are high, then tx_done=1 and go to IDLE.
  - Data=1 -> tx_err=1 and go to IDLE.
- Timeout counter:
  - Cleared on entry to RX, TX_BITS and TX_ACK, and on every fall.
  - Reaching TIMEOUT_CYCLES in RX aborts with rx_err=1.
  - Reaching it in TX_BITS or TX_ACK (including the wait-for-idle phase) aborts with tx_err=1.
  - On any abort: both oe=0 and state=IDLE next cycle.
- Constraints:
  - No strobe is ever asserted together with another strobe.
  - busy falls in the same cycle as the terminating strobe.
  - Falls seen during TX_INHIBIT (our own drive) are ignored.

Test Plan:
- RX good: device frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> single rx_valid, rx_data=0x1C, no rx_err.
- RX bad parity: 0x1C with parity=1 -> rx_err pulse, rx_valid stays 0, rx_data unchanged.
- TX good: cmd_data=0xED with FILTER_LEN=2 and INHIBIT_CYCLES=20 -> ps2_clk_oe high exactly 20 cycles; line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK low -> tx_done pulse.
- TX no-ACK: data held high at fall 11 -> tx_err pulse, both oe=0.
- Collision: cmd_valid asserted in the same cycle as the first device fall -> cmd_ready=0, frame received correctly, command accepted in the first IDLE cycle after rx_valid.
- Timeout/reset: clock stalls after 5 RX bits with TIMEOUT_CYCLES=100 -> rx_err after exactly 100 cycles. Reset asserted mid-TX_BITS -> both oe=0 immediately (asynchronous), busy=0, and no strobe is issued.

Source files
------------

// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 controller: receives checked device frames, sends host commands with ACK check.
// Pin-to-fall latency 2+FILTER_LEN cycles; cmd_ready only in IDLE with no device fall pending.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  // Abort is decided one cycle early so the registered strobe lands exactly
  // TIMEOUT_CYCLES cycles after the last fall.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_BITS, TX_ACK, TX_WAIT} state_t;

  state_t           state, state_d;
  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             filt, filt_q, fall;
  logic [FLT_W-1:0] flt_cnt;
  logic [3:0]       bit_cnt, bit_d;
  logic [INH_W-1:0] inh_cnt, inh_d, inh_nxt;
  logic [TO_W-1:0]  to_cnt, to_d, to_inc;
  logic             to_hit;
  logic [10:0]      rx_sh, rx_sh_d, frame;
  logic [7:0]       tx_byte, tx_byte_d, rx_data_d;
  logic             tx_par, tx_par_d;
  logic             drive_low, drive_d;
  logic             rx_valid_d, rx_err_d, tx_done_d, tx_err_d;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      filt    <= 1'b1;
      filt_q  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
      filt_q <= filt;
      if (clk_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt    <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign fall      = filt_q & ~filt;
  assign cmd_ready = (state == IDLE) && !fall && !Reset;
  assign busy      = (state != IDLE);
  assign ps2_dat_oe = drive_low;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      rx_sh      <= '0;
      tx_byte    <= '0;
      tx_par     <= 1'b0;
      drive_low  <= 1'b0;
      ps2_clk_oe <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_d;
      inh_cnt    <= inh_d;
      to_cnt     <= to_d;
      rx_sh      <= rx_sh_d;
      tx_byte    <= tx_byte_d;
      tx_par     <= tx_par_d;
      drive_low  <= drive_d;
      ps2_clk_oe <= (state_d == TX_INHIBIT);
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_err     <= rx_err_d;
      tx_done    <= tx_done_d;
      tx_err     <= tx_err_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_d      = bit_cnt;
    inh_d      = inh_cnt;
    to_d       = to_cnt;
    rx_sh_d    = rx_sh;
    tx_byte_d  = tx_byte;
    tx_par_d   = tx_par;
    drive_d    = drive_low;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    frame      = {dat_s2, rx_sh[10:1]};
    inh_nxt    = inh_cnt + INH_W'(1);
    to_inc     = to_cnt + TO_W'(1);
    to_hit     = (to_cnt == TO_LAST);

    case (state)
      IDLE: begin
        drive_d = 1'b0;
        if (fall) begin
          state_d = RX;
          rx_sh_d = frame;
          bit_d   = 4'd1;
          to_d    = '0;
        end else if (cmd_valid) begin
          state_d   = TX_INHIBIT;
          tx_byte_d = cmd_data;
          tx_par_d  = ~^cmd_data;
          inh_d     = '0;
          drive_d   = (INHIBIT_CYCLES == 1);
        end
      end
      RX: begin
        if (fall) begin
          rx_sh_d = frame;
          to_d    = '0;
          if (bit_cnt == 4'd10) begin
            state_d = IDLE;
            bit_d   = '0;
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
              rx_valid_d = 1'b1;
              rx_data_d  = frame[8:1];
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            bit_d = bit_cnt + 4'd1;
          end
        end else if (to_hit) begin
          state_d  = IDLE;
          bit_d    = '0;
          rx_err_d = 1'b1;
        end else begin
          to_d = to_inc;
        end
      end
      TX_INHIBIT: begin
        // Our own clock pull-down produces a fall here; it is deliberately ignored.
        if (inh_cnt == INH_LAST) begin
          state_d = TX_BITS;
          bit_d   = '0;
          to_d    = '0;
          drive_d = 1'b1;
        end else begin
          inh_d   = inh_nxt;
          drive_d = (inh_nxt == INH_LAST);
        end
      end
      TX_BITS: begin
        if (fall) begin
          to_d  = '0;
          bit_d = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            drive_d = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            drive_d = ~tx_par;
          end else begin
            drive_d = 1'b0;
            bit_d   = '0;
            state_d = TX_ACK;
          end
        end else if (to_hit) begin
          state_d  = IDLE;
          bit_d    = '0;
          drive_d  = 1'b0;
          tx_err_d = 1'b1;
        end else begin
          to_d = to_inc;
        end
      end
      TX_ACK: begin
        if (fall) begin
          to_d = '0;
          if (!dat_s2) begin
            state_d = TX_WAIT;
          end else begin
            state_d  = IDLE;
            tx_err_d = 1'b1;
          end
        end else if (to_hit) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end else begin
          to_d = to_inc;
        end
      end
      TX_WAIT: begin
        if (clk_s2 && dat_s2) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end else if (to_hit) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end else begin
          to_d = to_inc;
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Scoreboarded bench for ps2_host_ctrl: a device model drives an open-drain line pair,
// expected strobes are queued per transaction and popped by an independent monitor.
module tb_ps2_host_ctrl;

  localparam int INH  = 20;
  localparam int TO   = 100;
  localparam int FILT = 2;
  localparam int HALF = 10;

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic       dev_clk, dev_dat;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready, rx_valid, rx_err, tx_done, tx_err, busy;
  logic [7:0] rx_data;

  typedef struct packed {
    logic [1:0] kind;  // 0 rx_valid, 1 rx_err, 2 tx_done, 3 tx_err
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_ctrl #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FILT)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset(Reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_err(rx_err),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe pops one expected event.
  always @(negedge CLOCK_50) begin
    ev_t        e;
    logic [1:0] k;
    if (!Reset && (rx_valid || rx_err || tx_done || tx_err)) begin
      check("strobe_onehot", 32'($countones({rx_valid, rx_err, tx_done, tx_err})), 1);
      check("busy_at_strobe", busy, 0);
      k = rx_err ? 2'd1 : tx_done ? 2'd2 : tx_err ? 2'd3 : 2'd0;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got kind %0d, expected none", k);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", k, e.kind);
        if (e.kind < 2'd2) check("rx_data", rx_data, e.data);
      end
    end
  end

  task automatic idle_gap(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Device-to-host frame; nbits < 11 leaves the frame unfinished.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = f[i];
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
    end
    repeat (4) @(negedge CLOCK_50);
    dev_dat = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int g = 0;
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b1;
    cmd_data = b;
    @(negedge CLOCK_50);
    while (!cmd_ready && g < 200) begin
      @(negedge CLOCK_50);
      g++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
  endtask

  // Device side of a host command: observes inhibit, clocks 11 bits, optionally ACKs.
  task automatic device_rx(input logic ack, output logic [10:0] line, output int inh_len,
                           output logic dat_last);
    int g = 0;
    line = '0;
    inh_len = 0;
    dat_last = 1'b0;
    @(negedge CLOCK_50);
    while (!ps2_clk_oe && g < 500) begin
      @(negedge CLOCK_50);
      g++;
    end
    check("inhibit_seen", ps2_clk_oe, 1);
    if (ps2_clk_oe) begin
      while (ps2_clk_oe && g < 500) begin
        inh_len++;
        dat_last = ps2_dat_oe;
        @(negedge CLOCK_50);
        g++;
      end
      line[0] = ps2_dat_in;
      repeat (HALF) @(negedge CLOCK_50);
      for (int i = 1; i <= 10; i++) begin
        dev_clk = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        line[i] = ps2_dat_in;
        dev_clk = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
      end
      if (ack) dev_dat = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      dev_dat = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] line;
    int          inh_len;
    logic        dat_last;
    int          g;
    int          n;
    logic        hit;

    Reset = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_strobes", {rx_valid, rx_err, tx_done, tx_err}, 0);
    Reset = 1'b0;
    idle_gap(10);
    check("idle_cmd_ready", cmd_ready, 1);

    // Good receive of 0x1C: parity 0.
    expect_ev(2'd0, 8'h1C);
    send_frame(8'h1C, 1'b0, 11);
    idle_gap(30);

    // Bad parity: rx_err, rx_data still holds 0x1C.
    expect_ev(2'd1, 8'h1C);
    send_frame(8'h1C, 1'b1, 11);
    idle_gap(30);

    // Command 0xED: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1 -> 11'h7DA (bit0 first).
    expect_ev(2'd2, 8'h00);
    send_cmd(8'hED);
    device_rx(1'b1, line, inh_len, dat_last);
    check("tx_inhibit_len", inh_len, INH);
    check("tx_start_in_last_inhibit", dat_last, 1);
    check("tx_line_ed", line, 11'h7DA);
    idle_gap(30);

    // Command 0x55 with no ACK: line 11'h6AA, then tx_err and released pins.
    expect_ev(2'd3, 8'h00);
    send_cmd(8'h55);
    device_rx(1'b0, line, inh_len, dat_last);
    check("tx_line_55", line, 11'h6AA);
    check("noack_clk_oe", ps2_clk_oe, 0);
    check("noack_dat_oe", ps2_dat_oe, 0);
    idle_gap(30);

    // Collision: command raised in the first fall cycle (2+FILTER_LEN edges after the pin drop).
    expect_ev(2'd0, 8'h5A);
    expect_ev(2'd2, 8'h00);
    fork
      send_frame(8'h5A, 1'b0, 11);
      begin
        @(negedge dev_clk);
        repeat (1 + FILT) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("coll_ready_before_fall", cmd_ready, 1);
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b1;
        cmd_data = 8'hF4;
        @(negedge CLOCK_50);
        check("coll_ready_at_fall", cmd_ready, 0);
        g = 0;
        while (!cmd_ready && g < 400) begin
          @(negedge CLOCK_50);
          g++;
        end
        check("coll_accepted", cmd_ready, 1);
        check("coll_accept_with_rx_valid", rx_valid, 1);
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
      end
    join
    device_rx(1'b1, line, inh_len, dat_last);
    check("tx_line_f4", line, 11'h5E8);
    idle_gap(30);

    // Stall after 5 bits: rx_err TIMEOUT cycles after the 5th fall strobe.
    expect_ev(2'd1, 8'h5A);
    fork
      send_frame(8'h5A, 1'b0, 5);
      begin
        repeat (5) @(negedge dev_clk);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
          @(posedge CLOCK_50);
          n++;
          @(negedge CLOCK_50);
          if (rx_err) hit = 1'b1;
        end
        check("timeout_latency", n, 2 + FILT + TO);
      end
    join
    idle_gap(30);

    // Reset in the middle of TX_BITS with data held low.
    send_cmd(8'h00);
    g = 0;
    @(negedge CLOCK_50);
    while (!ps2_clk_oe && g < 100) begin
      @(negedge CLOCK_50);
      g++;
    end
    while (ps2_clk_oe && g < 200) begin
      @(negedge CLOCK_50);
      g++;
    end
    repeat (HALF) @(negedge CLOCK_50);
    repeat (3) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
    end
    check("midtx_busy", busy, 1);
    check("midtx_dat_oe", ps2_dat_oe, 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_clk_oe", ps2_clk_oe, 0);
    check("arst_dat_oe", ps2_dat_oe, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 0);
    check("arst_rx_data", rx_data, 8'h00);
    repeat (3) @(negedge CLOCK_50);
    Reset = 1'b0;
    idle_gap(50);
    check("post_reset_busy", busy, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
